// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters. Round-robin arbitration with a bounded
// lock extension feeds a two-stage pipeline that returns a tagged, registered result.

module alu_arbiter_alu (
   input  logic [3:0]  i_ctrl,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic [31:0] o_y
);
   always_comb begin
      o_y = 32'd0;
      case (i_ctrl)
         4'b0000: o_y = i_a & i_b;
         4'b0001: o_y = i_a | i_b;
         4'b0010: o_y = i_a + i_b;
         4'b0110: o_y = i_a - i_b;
         4'b0111: o_y = {31'd0, (i_a < i_b)};
         4'b1100: o_y = ~(i_a | i_b);
         default: o_y = 32'd0;
      endcase
   end
endmodule

module alu_arbiter #(
   parameter int LOCK_MAX = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        req0,
   input  logic        req1,
   input  logic        lock0,
   input  logic        lock1,
   input  logic [3:0]  ctrl0,
   input  logic [3:0]  ctrl1,
   input  logic [31:0] a0,
   input  logic [31:0] a1,
   input  logic [31:0] b0,
   input  logic [31:0] b1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        res_valid,
   output logic        res_id,
   output logic [31:0] res_data,
   output logic        busy
);
   localparam logic [3:0] LOCK_MAX_W = 4'(LOCK_MAX);

   logic        r_last;
   logic [3:0]  r_streak;
   logic        r_s1_valid;
   logic        r_s1_id;
   logic [3:0]  r_s1_ctrl;
   logic [31:0] r_s1_a;
   logic [31:0] r_s1_b;
   logic        r_res_valid;
   logic        r_res_id;
   logic [31:0] r_res_data;

   logic        w_both;
   logic        w_keep;
   logic        w_any;
   logic        w_gid;
   logic [31:0] w_alu_y;

   assign w_both = req0 & req1;
   // The last winner keeps the ALU on a tie only while it locks and has streak budget left.
   assign w_keep = (r_last ? lock1 : lock0) && (r_streak < LOCK_MAX_W);

   always_comb begin
      w_any = 1'b0;
      w_gid = 1'b0;
      if (!reset && !flush) begin
         if (w_both) begin
            w_any = 1'b1;
            w_gid = w_keep ? r_last : ~r_last;
         end else if (req0) begin
            w_any = 1'b1;
            w_gid = 1'b0;
         end else if (req1) begin
            w_any = 1'b1;
            w_gid = 1'b1;
         end
      end
   end

   assign gnt0 = w_any & ~w_gid;
   assign gnt1 = w_any & w_gid;

   alu_arbiter_alu u_alu (
      .i_ctrl (r_s1_ctrl),
      .i_a    (r_s1_a),
      .i_b    (r_s1_b),
      .o_y    (w_alu_y)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_last      <= 1'b1;
         r_streak    <= 4'd0;
         r_s1_valid  <= 1'b0;
         r_s1_id     <= 1'b0;
         r_s1_ctrl   <= 4'd0;
         r_s1_a      <= 32'd0;
         r_s1_b      <= 32'd0;
         r_res_valid <= 1'b0;
         r_res_id    <= 1'b0;
         r_res_data  <= 32'd0;
      end else begin
         if (w_any) begin
            r_last   <= w_gid;
            r_streak <= (w_both && (w_gid == r_last)) ? r_streak + 4'd1 : 4'd0;
            r_s1_id  <= w_gid;
            r_s1_ctrl <= w_gid ? ctrl1 : ctrl0;
            r_s1_a   <= w_gid ? a1 : a0;
            r_s1_b   <= w_gid ? b1 : b0;
         end
         r_s1_valid  <= w_any;
         // A flush drops the op sitting in stage 1 instead of promoting it.
         r_res_valid <= r_s1_valid & ~flush;
         r_res_id    <= r_s1_id;
         r_res_data  <= w_alu_y;
      end
   end

   assign res_valid = r_res_valid;
   assign res_id    = r_res_id;
   assign res_data  = r_res_data;
   assign busy      = r_s1_valid | r_res_valid;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: reset, op coverage, round-robin, lock streak,
// flush and mid-pipeline reset, each checked against hand-computed values.

module tb_alu_arbiter;
   logic        clk = 1'b0;
   logic        reset, flush, req0, req1, lock0, lock1;
   logic [3:0]  ctrl0, ctrl1;
   logic [31:0] a0, a1, b0, b1;
   logic        gnt0, gnt1, res_valid, res_id, busy;
   logic [31:0] res_data;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.LOCK_MAX(4)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
      .ctrl0(ctrl0), .ctrl1(ctrl1), .a0(a0), .a1(a1), .b0(b0), .b1(b1),
      .gnt0(gnt0), .gnt1(gnt1), .res_valid(res_valid), .res_id(res_id),
      .res_data(res_data), .busy(busy)
   );

   // Inputs change 1 time unit after the rising edge; checks happen 2 units later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; flush = 1'b0; req0 = 1'b1; req1 = 1'b1; lock0 = 1'b0; lock1 = 1'b0;
      ctrl0 = 4'd0; ctrl1 = 4'd0; a0 = 32'd0; a1 = 32'd0; b0 = 32'd0; b1 = 32'd0;
      step(); step();
      #2;
      n_total++; if (gnt0 !== 1'b0) $display("FAIL reset_gnt0 got %b want 0", gnt0); else n_pass++;
      n_total++; if (gnt1 !== 1'b0) $display("FAIL reset_gnt1 got %b want 0", gnt1); else n_pass++;
      n_total++; if (res_valid !== 1'b0) $display("FAIL reset_res_valid got %b want 0", res_valid); else n_pass++;
      n_total++; if (res_id !== 1'b0) $display("FAIL reset_res_id got %b want 0", res_id); else n_pass++;
      n_total++; if (res_data !== 32'd0) $display("FAIL reset_res_data got %h want 0", res_data); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
      step();
      reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
      $display("reset done");
   endtask

   task automatic test_single_add();
      step();
      req0 = 1'b1; ctrl0 = 4'b0010; a0 = 32'd7; b0 = 32'd5;
      #2;
      n_total++; if (gnt0 !== 1'b1) $display("FAIL add_gnt0 got %b want 1", gnt0); else n_pass++;
      n_total++; if (gnt1 !== 1'b0) $display("FAIL add_gnt1 got %b want 0", gnt1); else n_pass++;
      step();
      req0 = 1'b0;
      #2;
      n_total++; if (res_valid !== 1'b0) $display("FAIL add_early_valid got %b want 0", res_valid); else n_pass++;
      n_total++; if (busy !== 1'b1) $display("FAIL add_busy got %b want 1", busy); else n_pass++;
      step();
      #2;
      $display("add result valid=%b id=%0d data=%0d", res_valid, res_id, res_data);
      n_total++; if (res_valid !== 1'b1) $display("FAIL add_valid got %b want 1", res_valid); else n_pass++;
      n_total++; if (res_id !== 1'b0) $display("FAIL add_id got %b want 0", res_id); else n_pass++;
      n_total++; if (res_data !== 32'd12) $display("FAIL add_data got %0d want 12", res_data); else n_pass++;
      step(); step();
      #2;
      n_total++; if (busy !== 1'b0) $display("FAIL add_idle_busy got %b want 0", busy); else n_pass++;
   endtask

   task automatic test_ops();
      logic [3:0]  t_ctrl [9];
      logic [31:0] t_a [9];
      logic [31:0] t_b [9];
      logic [31:0] t_exp [9];
      t_ctrl[0] = 4'b0000; t_a[0] = 32'hF0F0_0000; t_b[0] = 32'h0FF0_0001; t_exp[0] = 32'h00F0_0000;
      t_ctrl[1] = 4'b0001; t_a[1] = 32'hF0F0_0000; t_b[1] = 32'h0FF0_0001; t_exp[1] = 32'hFFF0_0001;
      t_ctrl[2] = 4'b0110; t_a[2] = 32'hF0F0_0000; t_b[2] = 32'h0FF0_0001; t_exp[2] = 32'hE0FF_FFFF;
      t_ctrl[3] = 4'b0111; t_a[3] = 32'hF0F0_0000; t_b[3] = 32'h0FF0_0001; t_exp[3] = 32'h0000_0000;
      t_ctrl[4] = 4'b1100; t_a[4] = 32'hF0F0_0000; t_b[4] = 32'h0FF0_0001; t_exp[4] = 32'h000F_FFFE;
      t_ctrl[5] = 4'b0010; t_a[5] = 32'hF0F0_0000; t_b[5] = 32'h0FF0_0001; t_exp[5] = 32'h00E0_0001;
      t_ctrl[6] = 4'b0110; t_a[6] = 32'h0000_0000; t_b[6] = 32'h0000_0001; t_exp[6] = 32'hFFFF_FFFF;
      t_ctrl[7] = 4'b0111; t_a[7] = 32'hFFFF_FFFF; t_b[7] = 32'h0000_0001; t_exp[7] = 32'h0000_0000;
      t_ctrl[8] = 4'b0101; t_a[8] = 32'h1234_5678; t_b[8] = 32'h0000_0001; t_exp[8] = 32'h0000_0000;
      for (int k = 0; k < 11; k++) begin
         step();
         if (k < 9) begin
            req1 = 1'b1; ctrl1 = t_ctrl[k]; a1 = t_a[k]; b1 = t_b[k];
         end else begin
            req1 = 1'b0;
         end
         #2;
         if (k < 9) begin
            n_total++; if (gnt1 !== 1'b1) $display("FAIL ops_gnt1 k=%0d got %b want 1", k, gnt1); else n_pass++;
         end
         if (k >= 2) begin
            $display("op%0d ctrl=%b valid=%b id=%0d data=%h", k - 2, t_ctrl[k-2], res_valid, res_id, res_data);
            n_total++; if (res_valid !== 1'b1) $display("FAIL ops_valid op%0d got %b want 1", k - 2, res_valid); else n_pass++;
            n_total++; if (res_id !== 1'b1) $display("FAIL ops_id op%0d got %b want 1", k - 2, res_id); else n_pass++;
            n_total++; if (res_data !== t_exp[k-2]) $display("FAIL ops_data op%0d got %h want %h", k - 2, res_data, t_exp[k-2]); else n_pass++;
         end
      end
   endtask

   task automatic test_round_robin();
      logic e_id;
      logic r_id;
      a0 = 32'd1; b0 = 32'd0; ctrl0 = 4'b0010;
      a1 = 32'd2; b1 = 32'd0; ctrl1 = 4'b0010;
      for (int k = 0; k < 10; k++) begin
         step();
         req0 = (k < 8); req1 = (k < 8);
         #2;
         e_id = (k % 2) != 0;
         if (k < 8) begin
            n_total++; if (gnt0 !== ~e_id) $display("FAIL rr_gnt0 k=%0d got %b want %b", k, gnt0, ~e_id); else n_pass++;
            n_total++; if (gnt1 !== e_id) $display("FAIL rr_gnt1 k=%0d got %b want %b", k, gnt1, e_id); else n_pass++;
         end
         if (k >= 2) begin
            r_id = ((k - 2) % 2) != 0;
            $display("rr cycle%0d valid=%b id=%0d data=%0d", k, res_valid, res_id, res_data);
            n_total++; if (res_valid !== 1'b1) $display("FAIL rr_valid k=%0d got %b want 1", k, res_valid); else n_pass++;
            n_total++; if (res_id !== r_id) $display("FAIL rr_id k=%0d got %b want %b", k, res_id, r_id); else n_pass++;
            n_total++; if (res_data !== {31'd0, r_id} + 32'd1) $display("FAIL rr_data k=%0d got %0d want %0d", k, res_data, r_id + 1); else n_pass++;
         end
      end
   endtask

   task automatic test_lock();
      logic [11:0] seq;
      seq = 12'b1000_0010_0000;   // bit k = requester granted in cycle k
      lock0 = 1'b1;
      for (int k = 0; k < 14; k++) begin
         step();
         req0 = (k < 12); req1 = (k < 12);
         #2;
         if (k < 12) begin
            $display("lock cycle%0d gnt0=%b gnt1=%b", k, gnt0, gnt1);
            n_total++; if (gnt1 !== seq[k]) $display("FAIL lock_gnt1 k=%0d got %b want %b", k, gnt1, seq[k]); else n_pass++;
            n_total++; if (gnt0 !== ~seq[k]) $display("FAIL lock_gnt0 k=%0d got %b want %b", k, gnt0, ~seq[k]); else n_pass++;
         end
         if (k >= 2) begin
            n_total++; if (res_id !== seq[k-2] || res_valid !== 1'b1) $display("FAIL lock_res k=%0d got id=%b valid=%b want id=%b valid=1", k, res_id, res_valid, seq[k-2]); else n_pass++;
         end
      end
      lock0 = 1'b0;
   endtask

   task automatic test_flush();
      ctrl0 = 4'b0010; b0 = 32'd1;
      step();
      req0 = 1'b1; a0 = 32'd10;
      #2;
      n_total++; if (gnt0 !== 1'b1) $display("FAIL flush_gnt_c0 got %b want 1", gnt0); else n_pass++;
      step();
      a0 = 32'd20;
      #2;
      n_total++; if (gnt0 !== 1'b1) $display("FAIL flush_gnt_c1 got %b want 1", gnt0); else n_pass++;
      step();
      flush = 1'b1; a0 = 32'd30;
      #2;
      $display("flush cycle valid=%b id=%0d data=%0d", res_valid, res_id, res_data);
      n_total++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) $display("FAIL flush_gnt got %b%b want 00", gnt0, gnt1); else n_pass++;
      n_total++; if (res_valid !== 1'b1) $display("FAIL flush_res_valid got %b want 1", res_valid); else n_pass++;
      n_total++; if (res_data !== 32'd11) $display("FAIL flush_res_data got %0d want 11", res_data); else n_pass++;
      step();
      flush = 1'b0; req0 = 1'b0;
      #2;
      n_total++; if (res_valid !== 1'b0) $display("FAIL flush_c3_valid got %b want 0", res_valid); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL flush_c3_busy got %b want 0", busy); else n_pass++;
      step();
      #2;
      n_total++; if (res_valid !== 1'b0) $display("FAIL flush_c4_valid got %b want 0", res_valid); else n_pass++;
      step();
      req0 = 1'b1; req1 = 1'b1;
      #2;
      n_total++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) $display("FAIL flush_last_held got %b%b want gnt1", gnt0, gnt1); else n_pass++;
      step();
      req0 = 1'b0; req1 = 1'b0;
      step(); step();
   endtask

   task automatic test_reset_mid();
      step();
      req0 = 1'b1; ctrl0 = 4'b0010; a0 = 32'd5; b0 = 32'd5;
      #2;
      n_total++; if (gnt0 !== 1'b1) $display("FAIL rmid_gnt0 got %b want 1", gnt0); else n_pass++;
      step();
      reset = 1'b1; req1 = 1'b1;
      #2;
      n_total++; if (busy !== 1'b1) $display("FAIL rmid_busy_before got %b want 1", busy); else n_pass++;
      n_total++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) $display("FAIL rmid_gnt_in_reset got %b%b want 00", gnt0, gnt1); else n_pass++;
      step();
      reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
      #2;
      n_total++; if (res_valid !== 1'b0) $display("FAIL rmid_valid got %b want 0", res_valid); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b want 0", busy); else n_pass++;
      n_total++; if (res_data !== 32'd0) $display("FAIL rmid_data got %h want 0", res_data); else n_pass++;
      step();
      req0 = 1'b1; req1 = 1'b1;
      #2;
      n_total++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) $display("FAIL rmid_tie got %b%b want gnt0", gnt0, gnt1); else n_pass++;
      step();
      req0 = 1'b0; req1 = 1'b0;
      step(); step();
   endtask

   initial begin
      test_reset();
      test_single_add();
      test_ops();
      test_round_robin();
      test_lock();
      test_flush();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter and sequencer that shares one ALU instance between two requesters (e.g. main execute path and address/branch unit). Accepts operations through a req/gnt handshake, arbitrates round-robin with a bounded lock extension, and drives the ALU through a 2-stage pipeline that returns a tagged, registered result. Instantiates the team's existing ALU.

## Interface
- LOCK_MAX, 4: max consecutive contested grants a locking requester may take beyond its round-robin turn (1..15).
- clk  in  1  single clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  squash all in-flight operations; blocks grants this cycle.
- req0 / req1  in  1  requester i has a valid operation.
- lock0 / lock1  in  1  requester i asks to keep the ALU on back-to-back ops.
- ctrl0 / ctrl1  in  4  ALU control code for requester i.
- a0 / a1, b0 / b1  in  32  operands for requester i.
- gnt0 / gnt1  out  1  combinational; operation of requester i accepted this cycle.
- res_valid  out  1  result bus valid (registered).
- res_id  out  1  requester owning res_data.
- res_data  out  32  ALU result.
- busy  out  1  s1_valid | res_valid.

## Operation
- Control codes: 0000 AND, 0001 OR, 0010 add, 0110 sub, 0111 slt (unsigned compare, result 1 or 0), 1100 NOR; any other code yields 0. Add/sub wrap modulo 2^32, no flags.
- State: last (id of last grant, resets to 1 so requester 0 wins the first tie), streak (4-bit, resets 0), stage-1 register {s1_valid, s1_id, s1_ctrl, s1_a, s1_b}, result register {res_valid, res_id, res_data}.
- Grant rules (reset=0, flush=0): at most one gnt per cycle. Only one req high -> grant it. Both high -> grant requester != last, unless lock[last]=1 and streak < LOCK_MAX, in which case grant last.
- streak update on a grant: if both req high and granted id == last -> streak+1; otherwise -> 0. No grant -> streak holds.
- last <= granted id on every grant.
- Requesters must hold req/ctrl/a/b stable until gnt; gnt is combinational from req, lock, last, streak, flush, reset only (no path from ctrl/a/b).
- Stage 1: on grant, s1 captures id/ctrl/a/b, s1_valid<=1; otherwise s1_valid<=0.
- Stage 2: res_data <= ALU(s1_ctrl, s1_a, s1_b), res_id <= s1_id, res_valid <= s1_valid.
- No result backpressure: each requester consumes its result in the single cycle res_valid=1 with matching res_id.
- flush: gnt0=gnt1=0 that cycle; at the edge s1_valid<=0 and res_valid<=0; last and streak hold. Result visible during the flush cycle is still valid; the op in s1 is dropped.
- reset: gnt0=gnt1=0 during reset; at edge all registers cleared (res_valid/res_id/res_data/busy = 0, s1 cleared, streak=0, last=1). Reset mid-pipeline discards all in-flight ops.
- reset has priority over flush; flush over grant.

## Timing
- Grant in cycle N -> res_valid=1 with result in cycle N+2. Throughput one op per cycle, fully pipelined.
- Back-to-back grants produce back-to-back res_valid cycles in grant order.
- Flush in cycle N kills grants of cycles N-1 and N; a grant issued in N-2 still returns in N.
- busy reflects registered state only; falls 2 cycles after last grant if no new grants.
- No combinational path from any input to res_*.

## Test plan
- Reset, then req0=1 ctrl0=0010 a0=7 b0=5 held one cycle -> gnt0=1 same cycle, two cycles later res_valid=1 res_id=0 res_data=12; all outputs 0 during reset.
- Op coverage on port 1: AND/OR/sub/slt/NOR on a=0xF0F0_0000 b=0x0FF0_0001, plus sub 0-1 -> 0xFFFF_FFFF, slt 0xFFFF_FFFF<1 -> 0, undefined ctrl 0101 -> 0.
- Both req continuously, no lock -> grants alternate 0,1,0,1...; res_id sequence matches, one result per cycle.
- Both req continuously, lock0=1, LOCK_MAX=4 -> gnt0 for cycles 0..4 (5 grants), gnt1 at cycle 5, then alternation resumes while lock0 contested by streak rule.
- Grants in cycles 0,1,2, flush=1 in cycle 2 -> no gnt in cycle 2; only cycle-0 result appears (cycle 2); res_valid=0 in cycles 3,4; last/streak unchanged.
- reset asserted in cycle 1 with ops in flight -> next cycle res_valid=0, busy=0, first subsequent tie grants requester 0.
